tpu_mac_sequencer: RTL and testbench
====================================

# tpu_mac_sequencer

Sequences one decoded MAC instruction into tiled work for the 32x32 systolic MAC array. It sits between the instruction decoder and the datapath. It walks the V/U/ITER tile loops and requests one weight-tile load per (v,u) tile. It streams activation-row reads from the unified buffer, and emits matching accumulator write addresses with accumulate flags, delayed to line up with array latency. It signals completion and illegal opcodes back to the decoder.

## Interface
- `ADDR_W`, 12: unified buffer / accumulator address width.
- `DIM_W`, 7: tile-count width (matches `V_dim1`/`U_dim1`/`ITER_dim1`).
- `LAT`, 64: cycles from activation-read transfer to result-write issue (2*MUL_SIZE).

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `cmd_valid` in 1: decoded instruction valid.
- `cmd_ready` out 1: sequencer can accept a command.
- `cmd_op` in 3: MAC_op (0 NOP, 1 MATMUL, other values illegal).
- `cmd_v_tiles`, `cmd_u_tiles`, `cmd_iter` in DIM_W each: V tiles, U tiles, rows per tile.
- `cmd_rd_base`, `cmd_wr_base` in ADDR_W: activation read base, accumulator write base.
- `w_load_req` out 1, `w_load_ack` in 1: weight-tile load handshake.
- `w_tile_idx` out 2*DIM_W: {v_idx,u_idx} of the requested weight tile.
- `act_rd_en` out 1, `act_rd_ready` in 1, `act_rd_addr` out ADDR_W: activation row read.
- `acc_wr_en` out 1, `acc_wr_addr` out ADDR_W, `acc_wr_accum` out 1: result write; accum=1 means add to stored partial sum.
- `done` out 1: one-cycle completion pulse.
- `err_illegal` out 1: one-cycle illegal-opcode pulse.
- `perf_busy_cycles`, `perf_stall_cycles` out 32: performance counters (see Configuration).

## Operation
- States: IDLE, LOAD_W, STREAM, DRAIN, DONE.
- IDLE:
  - `cmd_ready`=1; a command is accepted when `cmd_valid`&&`cmd_ready`.
  - Fields are latched and v_idx=u_idx=i=0.
- On acceptance:
  - op=1 with all three dims nonzero → LOAD_W.
  - op=0, or any dim=0 → DONE.
  - op∉{0,1} → DONE with `err_illegal` pulsed together with `done`.
- LOAD_W:
  - `w_load_req`=1 and `w_tile_idx`={v_idx,u_idx}; both are held until `w_load_ack`.
  - The ack cycle completes the handshake → STREAM with i=0.
- STREAM:
  - `act_rd_en`=1, `act_rd_addr`=rd_base + u_idx*ITER + i.
  - A transfer occurs when `act_rd_ready`=1; each transfer increments i.
  - On the transfer with i=ITER-1:
    - u_idx<U-1 → u_idx++, LOAD_W.
    - else v_idx<V-1 → v_idx++, u_idx=0, LOAD_W.
    - else → DRAIN.
- Address generation uses running accumulators, with no multipliers:
  - row_base advances by ITER per u tile and resets to rd_base at each new v.
  - out_base advances by ITER per v tile.
- Each transfer pushes {valid, addr=wr_base + v_idx*ITER + i, accum=(u_idx!=0)} into a LAT-deep delay line.
  - The delay line shifts every cycle. Non-transfer cycles push valid=0.
  - Its head drives `acc_wr_en`/`acc_wr_addr`/`acc_wr_accum`.
- DRAIN: waits until the delay line holds no valid entries → DONE.
- DONE: `done`=1 for one cycle → IDLE.
- Arithmetic: all address sums are ADDR_W bits, modulo 2^ADDR_W. Wrap past 0xFFF is silent.

## Timing
- Reset values: state=IDLE, `cmd_ready`=1 (the first cycle after reset). All other outputs 0, all delay-line valids 0, counters 0.
- Reset mid-operation aborts the command. No further writes or `done` are issued.
- Acceptance at cycle T → `w_load_req` at T+1, or `done` at T+1 for NOP/zero-dim/illegal commands.
- `w_load_ack` at cycle A → first `act_rd_en` at A+1.
- A read transfer at cycle R → `acc_wr_en` at exactly R+LAT.
- `done` is asserted the cycle after the last `acc_wr_en`.
- `cmd_ready` is 0 from the cycle after acceptance until the cycle after `done`.
- The earliest next acceptance is the cycle after `done`.
- If `w_load_ack` is already high when `w_load_req` rises, the handshake completes in that same cycle.
- `act_rd_ready` low holds `act_rd_addr` stable and pushes bubbles into the delay line.

## Configuration
- `TPU_SEQ_PERF_EN` defined:
  - `perf_busy_cycles` counts cycles with state≠IDLE.
  - `perf_stall_cycles` counts cycles with `act_rd_en`&&!`act_rd_ready` or `w_load_req`&&!`w_load_ack`.
  - Both are 32-bit, saturating, and cleared only by reset.
- Not defined: both ports are tied to 0 and no counter logic exists. Port list is unchanged.

## Test plan
- V=1,U=1,ITER=1, rd_base=0x010, wr_base=0x020, ack and ready always high → one weight req with idx {0,0}; one read of 0x010; one write of 0x020 with accum=0 exactly LAT cycles later; `done` the next cycle.
- V=2,U=2,ITER=3, rd_base=0x100, wr_base=0x200:
  - weight idx order {0,0},{0,1},{1,0},{1,1}.
  - read order 0x100–0x105 twice.
  - writes 0x200–0x202 accum=0, then 0x200–0x202 accum=1, then 0x203–0x205 accum=0, then 0x203–0x205 accum=1.
- Same command with `act_rd_ready` toggling 1-0 and `w_load_ack` delayed 5 cycles → identical address sequences. Each write lands exactly LAT cycles after its transfer. With the macro defined, perf_stall_cycles equals the counted stall cycles.
- cmd_op=5 → `done` and `err_illegal` together at T+1, with no req/read/write. A NOP, and MATMUL with U=0, each → `done` at T+1 only.
- rd_base=0xFFE, ITER=4 → reads 0xFFE,0xFFF,0x000,0x001.
- Assert `rst` while in STREAM with writes in flight → the following cycle shows IDLE, `cmd_ready`=1, no `acc_wr_en` afterward, and no `done`.

Source files
------------

// File: rtl/tpu_mac_sequencer.sv
// tpu_mac_sequencer: walks V/U/ITER tile loops of one MAC command, issuing weight loads, activation reads and delayed accumulator writes.
// Optional performance counters are built only when TPU_SEQ_PERF_EN is defined.
module tpu_mac_sequencer #(
  parameter int ADDR_W = 12,
  parameter int DIM_W  = 7,
  parameter int LAT    = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_op,
  input  logic [DIM_W-1:0]     cmd_v_tiles,
  input  logic [DIM_W-1:0]     cmd_u_tiles,
  input  logic [DIM_W-1:0]     cmd_iter,
  input  logic [ADDR_W-1:0]    cmd_rd_base,
  input  logic [ADDR_W-1:0]    cmd_wr_base,
  output logic                 w_load_req,
  input  logic                 w_load_ack,
  output logic [2*DIM_W-1:0]   w_tile_idx,
  output logic                 act_rd_en,
  input  logic                 act_rd_ready,
  output logic [ADDR_W-1:0]    act_rd_addr,
  output logic                 acc_wr_en,
  output logic [ADDR_W-1:0]    acc_wr_addr,
  output logic                 acc_wr_accum,
  output logic                 done,
  output logic                 err_illegal,
  output logic [31:0]          perf_busy_cycles,
  output logic [31:0]          perf_stall_cycles
);
  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [DIM_W-1:0] v_n_q, u_n_q, iter_q, v_q, u_q, i_q;
  logic [ADDR_W-1:0] rd_base_q, row_base_q, out_base_q;
  logic err_q;
  logic accept, dims_ok, xfer, last_i, last_u, last_v, in_flight;
  logic [LAT-1:0] pv_q;
  logic [ADDR_W:0] pd_q [LAT];
  assign accept    = cmd_valid && cmd_ready;
  assign dims_ok   = |cmd_v_tiles && |cmd_u_tiles && |cmd_iter;
  assign xfer      = act_rd_en && act_rd_ready;
  assign last_i    = i_q == iter_q - 1'b1;
  assign last_u    = u_q == u_n_q - 1'b1;
  assign last_v    = v_q == v_n_q - 1'b1;
  // the head entry is being written this cycle, so it no longer counts as pending
  assign in_flight = |pv_q[LAT-2:0];
  always_ff @(posedge clk)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = !accept ? IDLE : (cmd_op == 3'd1 && dims_ok) ? LOAD_W : DONE;
      LOAD_W:  state_d = w_load_ack ? STREAM : LOAD_W;
      STREAM:  state_d = !(xfer && last_i) ? STREAM : (last_u && last_v) ? DRAIN : LOAD_W;
      DRAIN:   state_d = in_flight ? DRAIN : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    cmd_ready    = state_q == IDLE;
    w_load_req   = state_q == LOAD_W;
    act_rd_en    = state_q == STREAM;
    done         = state_q == DONE;
    err_illegal  = state_q == DONE && err_q;
    w_tile_idx   = {v_q, u_q};
    act_rd_addr  = row_base_q + ADDR_W'(i_q);
    acc_wr_en    = pv_q[LAT-1];
    acc_wr_addr  = pv_q[LAT-1] ? pd_q[LAT-1][ADDR_W-1:0] : '0;
    acc_wr_accum = pv_q[LAT-1] && pd_q[LAT-1][ADDR_W];
  end
  always_ff @(posedge clk)
    if (rst) begin
      {v_n_q, u_n_q, iter_q, v_q, u_q, i_q} <= '0;
      {rd_base_q, row_base_q, out_base_q} <= '0;
      err_q <= 1'b0;
      pv_q  <= '0;
    end else begin
      pv_q <= {pv_q[LAT-2:0], xfer};
      if (accept) begin
        v_n_q      <= cmd_v_tiles;
        u_n_q      <= cmd_u_tiles;
        iter_q     <= cmd_iter;
        rd_base_q  <= cmd_rd_base;
        row_base_q <= cmd_rd_base;
        out_base_q <= cmd_wr_base;
        {v_q, u_q, i_q} <= '0;
        err_q      <= cmd_op > 3'd1;
      end
      if (xfer) i_q <= last_i ? '0 : i_q + 1'b1;
      if (xfer && last_i && !last_u) begin
        u_q        <= u_q + 1'b1;
        row_base_q <= row_base_q + ADDR_W'(iter_q);
      end else if (xfer && last_i && !last_v) begin
        v_q        <= v_q + 1'b1;
        u_q        <= '0;
        row_base_q <= rd_base_q;
        out_base_q <= out_base_q + ADDR_W'(iter_q);
      end
    end
  // payload needs no reset: it is only observed through the valid bits
  always_ff @(posedge clk) begin
    pd_q[0] <= {u_q != '0, out_base_q + ADDR_W'(i_q)};
    for (int k = 1; k < LAT; k++) pd_q[k] <= pd_q[k-1];
  end
`ifdef TPU_SEQ_PERF_EN
  logic [31:0] busy_q, stall_q;
  always_ff @(posedge clk)
    if (rst) begin
      busy_q  <= '0;
      stall_q <= '0;
    end else begin
      if (state_q != IDLE && ~&busy_q) busy_q <= busy_q + 32'd1;
      if (((act_rd_en && !act_rd_ready) || (w_load_req && !w_load_ack)) && ~&stall_q) stall_q <= stall_q + 32'd1;
    end
  assign perf_busy_cycles  = busy_q;
  assign perf_stall_cycles = stall_q;
`else
  assign perf_busy_cycles  = '0;
  assign perf_stall_cycles = '0;
`endif
endmodule

// File: tb/tb_tpu_mac_sequencer.sv
// tb_tpu_mac_sequencer: scoreboard bench; a loop-level reference model fills expectation queues, a negedge monitor checks DUT traffic.
module tb_tpu_mac_sequencer;
  localparam int ADDR_W = 12, DIM_W = 7, LAT = 64;
  logic clk = 0, rst = 1, cmd_valid = 0;
  logic cmd_ready, w_load_req, act_rd_en, acc_wr_en, acc_wr_accum, done, err_illegal;
  logic w_load_ack = 0, act_rd_ready = 0;
  logic [2:0] cmd_op = 0;
  logic [DIM_W-1:0] cmd_v_tiles = 0, cmd_u_tiles = 0, cmd_iter = 0;
  logic [ADDR_W-1:0] cmd_rd_base = 0, cmd_wr_base = 0, act_rd_addr, acc_wr_addr;
  logic [2*DIM_W-1:0] w_tile_idx;
  logic [31:0] perf_busy_cycles, perf_stall_cycles;

  tpu_mac_sequencer #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_v_tiles(cmd_v_tiles), .cmd_u_tiles(cmd_u_tiles), .cmd_iter(cmd_iter),
    .cmd_rd_base(cmd_rd_base), .cmd_wr_base(cmd_wr_base),
    .w_load_req(w_load_req), .w_load_ack(w_load_ack), .w_tile_idx(w_tile_idx),
    .act_rd_en(act_rd_en), .act_rd_ready(act_rd_ready), .act_rd_addr(act_rd_addr),
    .acc_wr_en(acc_wr_en), .acc_wr_addr(acc_wr_addr), .acc_wr_accum(acc_wr_accum),
    .done(done), .err_illegal(err_illegal),
    .perf_busy_cycles(perf_busy_cycles), .perf_stall_cycles(perf_stall_cycles));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk = 0, n_fail = 0;
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  logic [13:0] wq[$];
  logic [11:0] rq[$];
  logic [12:0] wrq[$];
  int rt[$];
  bit dq_err[$];
  int dq_cyc[$];
  int last_wr = 0, n_xfer = 0, tb_stall = 0, tb_busy = 0;

  // ack arrives after ack_dly cycles of request (always high when negative)
  int ack_dly = -1, rdy_mode = 0, wcnt = 0;
  always @(posedge clk) begin
    #1;
    wcnt = w_load_req ? wcnt + 1 : 0;
    w_load_ack = ack_dly < 0 || wcnt > ack_dly;
    act_rd_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    if (rst) begin
      tb_stall = 0;
      tb_busy = 0;
    end else begin
      if ((act_rd_en && !act_rd_ready) || (w_load_req && !w_load_ack)) tb_stall++;
      if (!cmd_ready) tb_busy++;
      if (w_load_req && w_load_ack) begin
        if (wq.size() == 0) check("widx_extra", 1, 0);
        else check("widx", w_tile_idx, wq.pop_front());
      end
      if (act_rd_en && act_rd_ready) begin
        n_xfer++;
        rt.push_back(cyc);
        if (rq.size() == 0) check("rd_extra", 1, 0);
        else check("rd_addr", act_rd_addr, rq.pop_front());
      end
      if (acc_wr_en) begin
        last_wr = cyc;
        if (wrq.size() == 0) check("wr_extra", 1, 0);
        else check("wr_addr_accum", {acc_wr_accum, acc_wr_addr}, wrq.pop_front());
        if (rt.size() != 0) check("wr_latency", cyc - rt.pop_front(), LAT);
      end
      if (done) begin
        if (dq_err.size() == 0) check("done_extra", 1, 0);
        else begin
          int ec;
          ec = dq_cyc.pop_front();
          check("err_with_done", err_illegal, dq_err.pop_front());
          check("done_cycle", cyc, ec < 0 ? last_wr + 1 : ec);
        end
      end else if (err_illegal) check("err_without_done", 1, 0);
    end
  end

  // reference model: straight loop nest over the tiles, plain modular arithmetic
  task automatic model(input logic [2:0] op, input int v, u, it, input logic [11:0] rb, wb);
    if (op == 3'd1 && v > 0 && u > 0 && it > 0)
      for (int vv = 0; vv < v; vv++)
        for (int uu = 0; uu < u; uu++) begin
          wq.push_back({7'(vv), 7'(uu)});
          for (int i = 0; i < it; i++) begin
            rq.push_back(12'(int'(rb) + uu * it + i));
            wrq.push_back({uu != 0, 12'(int'(wb) + vv * it + i)});
          end
        end
    dq_err.push_back(op > 3'd1);
  endtask

  task automatic issue(input logic [2:0] op, input int v, u, it, input logic [11:0] rb, wb);
    bit work;
    int k;
    work = op == 3'd1 && v > 0 && u > 0 && it > 0;
    k = 0;
    model(op, v, u, it, rb, wb);
    @(negedge clk);
    while (!cmd_ready && k < 5000) begin @(negedge clk); k++; end
    if (!cmd_ready) check("ready_timeout", 0, 1);
    cmd_valid = 1; cmd_op = op;
    cmd_v_tiles = 7'(v); cmd_u_tiles = 7'(u); cmd_iter = 7'(it);
    cmd_rd_base = rb; cmd_wr_base = wb;
    @(posedge clk);
    #1 cmd_valid = 0;
    dq_cyc.push_back(work ? -1 : cyc);
    @(negedge clk);
    check("ready_low_after_accept", cmd_ready, 0);
    if (work) check("req_at_t1", w_load_req, 1);
    else check("done_at_t1", done, 1);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!done && k < 20000) begin @(negedge clk); k++; end
    if (!done) check("done_timeout", 0, 1);
    @(negedge clk);
    check("leftover_expectations", wq.size() + rq.size() + wrq.size() + dq_err.size(), 0);
    check("ready_after_done", cmd_ready, 1);
  endtask

  task automatic run(input logic [2:0] op, input int v, u, it, input logic [11:0] rb, wb);
    issue(op, v, u, it, rb, wb);
    wait_done();
  endtask

  task automatic perf_chk();
`ifdef TPU_SEQ_PERF_EN
    check("perf_stall", perf_stall_cycles, tb_stall);
    check("perf_busy", perf_busy_cycles, tb_busy);
`else
    check("perf_tied_off", {perf_busy_cycles, perf_stall_cycles}, 0);
`endif
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_outputs", {w_load_req, act_rd_en, acc_wr_en, done, err_illegal, acc_wr_addr, act_rd_addr}, 0);
    perf_chk();

    run(3'd1, 1, 1, 1, 12'h010, 12'h020);
    run(3'd1, 2, 2, 3, 12'h100, 12'h200);
    perf_chk();

    ack_dly = 5; rdy_mode = 1;
    run(3'd1, 2, 2, 3, 12'h100, 12'h200);
    perf_chk();
    ack_dly = 0;
    run(3'd1, 1, 2, 2, 12'h040, 12'h080);

    ack_dly = -1; rdy_mode = 0;
    run(3'd5, 2, 2, 3, 12'h100, 12'h200);
    run(3'd0, 2, 2, 3, 12'h100, 12'h200);
    run(3'd1, 2, 0, 3, 12'h100, 12'h200);
    run(3'd1, 1, 1, 4, 12'hFFE, 12'hFFD);

    rdy_mode = 2;
    for (int n = 0; n < 8; n++) begin
      logic [2:0] op;
      int v, u, it;
      op = ($urandom % 6 == 0) ? 3'($urandom_range(2, 7)) : ($urandom % 8 == 0) ? 3'd0 : 3'd1;
      v = $urandom_range(1, 3);
      u = ($urandom % 8 == 0) ? 0 : $urandom_range(1, 3);
      it = $urandom_range(1, 5);
      ack_dly = $urandom_range(0, 3);
      run(op, v, u, it, 12'($urandom), 12'($urandom));
    end
    perf_chk();

    ack_dly = -1; rdy_mode = 0;
    begin
      int k, start;
      bit bad;
      start = n_xfer;
      issue(3'd1, 2, 2, 3, 12'h100, 12'h200);
      k = 0;
      while (n_xfer < start + 4 && k < 1000) begin @(negedge clk); k++; end
      check("reached_stream", n_xfer >= start + 4, 1);
      @(posedge clk); #1 rst = 1;
      @(posedge clk); #1 rst = 0;
      wq.delete(); rq.delete(); wrq.delete(); rt.delete(); dq_err.delete(); dq_cyc.delete();
      @(negedge clk);
      check("post_rst_ready", cmd_ready, 1);
      check("post_rst_idle", {w_load_req, act_rd_en}, 0);
      bad = 0;
      repeat (LAT + 8) begin
        @(negedge clk);
        if (acc_wr_en || done) bad = 1;
      end
      check("post_rst_quiet", bad, 0);
    end
    run(3'd1, 1, 1, 2, 12'h300, 12'h400);
    perf_chk();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
